counter_ff_sub_dec: RTL and testbench
=====================================

// Module: counter_ff_sub_dec
// PURPOSE
//  Loadable down-counter (countdown timer), the decrementing counterpart of the team's FF+adder up-counter.
//  Built from a flip-flop register and an adder with an inverted operand: decrement = count + ~0.
//  Loaded with a start value, it counts down on enable and pulses done at terminal count (zero).
//  Used as a delay/timeout generator beside the up-counter; optional auto-reload gives a periodic tick.
// PARAMETERS
//  WIDTH        4   counter width in bits (>=2)
//  AUTO_RELOAD  0   1: reload last loaded value after done and keep running; 0: stop at zero
// PORTS
//  clk         in   1      rising-edge clock
//  reset       in   1      synchronous, active-high reset
//  enable      in   1      count-down qualifier; when low in RUN, count holds
//  load        in   1      load request, one cycle; captures load_value
//  load_value  in   WIDTH  start value; also stored as the reload value
//  count       out  WIDTH  current counter value (registered)
//  busy        out  1      1 while state==RUN
//  done        out  1      1-cycle pulse, high exactly while state==DONE (count==0)
// BEHAVIOUR
//  Reset (sync, highest priority): count=0, reload_reg=0, busy=0, done=0, state=IDLE.
//  States: IDLE -> RUN -> DONE -> (IDLE | RUN); all outputs registered or decoded from state.
//  Priority each cycle: reset > load > decrement/hold > state default.
//  load=1, any state: count<=load_value, reload_reg<=load_value next cycle (latency 1);
//    load_value!=0 -> RUN; load_value==0 -> IDLE, no done pulse.
//  RUN, enable=1: count<=count+{WIDTH{1'b1}} (mod 2^WIDTH); if count==1 -> next state DONE.
//  RUN, enable=0: count, state hold.
//  DONE (exactly 1 cycle): done=1, count==0, busy=0.
//    AUTO_RELOAD=0 -> IDLE, count stays 0.
//    AUTO_RELOAD=1 -> count<=reload_reg, state RUN (reload_reg!=0 guaranteed by load rule).
//  IDLE: count holds; enable ignored; no wrap below 0 (counter never wraps to all-ones).
//  load during DONE: done still 1 that cycle; load wins over reload; next state per load rule.
//  load during RUN: restarts count; no done pulse for the aborted run.
//  reset mid-run: next cycle count=0, IDLE, no done pulse.
//  Period with AUTO_RELOAD=1, enable held 1: reload_reg+1 cycles between done pulses.
// STRUCTURE
//  Shared package/include counter_defs: state encoding localparams ST_IDLE=2'd0, ST_RUN=2'd1,
//    ST_DONE=2'd2; CNT_W default width constant shared with the up-counter.
//  One sub-module: ff_reg_sync (parameterised WIDTH register, sync active-high reset, load enable),
//    instantiated for count and reload_reg; state register and decrement adder in the top.
// TESTING
//  1. reset=1 for 2 cycles, load=1 concurrently -> count=0, busy=0, done=0; load ignored.
//  2. AUTO_RELOAD=0, load 5, enable=1 -> count 5,4,3,2,1,0; done=1 only in the count==0 cycle;
//     busy=1 for counts 5..1; afterwards count stays 0, busy=0.
//  3. load 3, enable=0 for 3 cycles -> count holds 3, busy=1; enable=1 -> 2,1,0 with one done pulse.
//  4. load 9 (WIDTH=4), at count==2 load 12 -> next count 12, no done pulse; continues 11,10,...
//  5. load 6, reset at count==3 -> next cycle count=0, busy=0, done=0; load 0 -> no done, busy=0.
//  6. AUTO_RELOAD=1, load 2, enable=1 -> count 2,1,0,2,1,0,...; done every 3rd cycle; load in DONE
//     cycle with value 4 -> next count 4, not 2.

Source files
------------

// File: rtl/counter_ff_sub_dec_pkg.sv
// -----------------------------------------------------------------------------
// counter_defs
//   Definitions shared by the FF+adder counter family (up-counter and the
//   countdown timer counter_ff_sub_dec).
//
//   CNT_W     default counter width used by both counters
//   state_t   control-state encoding; the literal values are fixed so that
//             both counters decode state identically:
//             ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2
// -----------------------------------------------------------------------------
package counter_defs;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage : counter_defs

// File: rtl/counter_ff_sub_dec_ff_reg_sync.sv
// -----------------------------------------------------------------------------
// ff_reg_sync
//   Parameterised WIDTH-bit register with a synchronous active-high reset and a
//   load enable. Used for both the live count and the stored reload value.
//
// Ports
//   clk    in  1      rising-edge clock
//   reset  in  1      synchronous, active-high; clears q to zero (wins over en)
//   en     in  1      when high, q captures d on the next rising edge
//   d      in  WIDTH  data to capture
//   q      out WIDTH  registered value
// -----------------------------------------------------------------------------
module ff_reg_sync #(
  parameter int WIDTH = counter_defs::CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // NOTE: sequential state is assigned with <= so every register samples the
  // pre-edge values of its inputs, independent of block evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule : ff_reg_sync

// File: rtl/counter_ff_sub_dec.sv
// -----------------------------------------------------------------------------
// counter_ff_sub_dec
//   Loadable countdown timer: the decrementing counterpart of the FF+adder
//   up-counter. A register holds the count; the decrement is an adder whose
//   second operand is the inverted zero constant (count + ~0 == count - 1).
//   After a load the counter runs down on enable, spends exactly one cycle in
//   DONE (count == 0, done high), then either stops (AUTO_RELOAD=0) or restarts
//   from the last loaded value (AUTO_RELOAD=1), giving a periodic tick of
//   reload+1 cycles when enable is held high.
//
// Parameters
//   WIDTH        counter width in bits (>= 2)
//   AUTO_RELOAD  1: reload after done and keep running; 0: stop at zero
//
// Ports
//   clk         in  1      rising-edge clock
//   reset       in  1      synchronous, active-high; highest priority
//   enable      in  1      count-down qualifier while running; ignored otherwise
//   load        in  1      one-cycle load request; captures load_value
//   load_value  in  WIDTH  start value, also kept as the reload value
//   count       out WIDTH  current counter value (registered)
//   busy        out 1      high while running
//   done        out 1      one-cycle pulse at terminal count (count == 0)
// -----------------------------------------------------------------------------
module counter_ff_sub_dec
  import counter_defs::*;
#(
  parameter int WIDTH       = CNT_W,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  if (WIDTH < 2) begin : g_width_check
    $error("counter_ff_sub_dec: WIDTH must be at least 2");
  end

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] reload_q;
  logic [WIDTH-1:0] count_d;
  logic             count_en;
  logic [WIDTH-1:0] count_dec;
  logic             at_one;

  // ---------------------------------------------------------------------------
  // Datapath: decrement by adding all-ones (two's complement -1). Only used in
  // RUN, where the count is never zero, so it cannot wrap to all-ones.
  // ---------------------------------------------------------------------------
  assign count_dec = count + ~{WIDTH{1'b0}};
  assign at_one    = (count == ONE);

  ff_reg_sync #(.WIDTH(WIDTH)) u_count_reg (
    .clk   (clk),
    .reset (reset),
    .en    (count_en),
    .d     (count_d),
    .q     (count)
  );

  // The reload value tracks every load, including a load of zero; a zero load
  // parks the counter in IDLE, so DONE can never reload a zero.
  ff_reg_sync #(.WIDTH(WIDTH)) u_reload_reg (
    .clk   (clk),
    .reset (reset),
    .en    (load),
    .d     (load_value),
    .q     (reload_q)
  );

  // ---------------------------------------------------------------------------
  // Control: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Control: next state and count update. Load outranks everything but reset,
  // so a load in DONE replaces the reload and a load in RUN aborts the run
  // without ever passing through DONE.
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first, so no path through
  // the case/if tree can leave it unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    count_d  = count;
    count_en = 1'b0;

    if (load) begin
      count_d  = load_value;
      count_en = 1'b1;
      state_d  = (load_value != '0) ? ST_RUN : ST_IDLE;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (enable) begin
            count_d  = count_dec;
            count_en = 1'b1;
            if (at_one) begin
              state_d = ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (AUTO_RELOAD) begin
            count_d  = reload_q;
            count_en = 1'b1;
            state_d  = ST_RUN;
          end else begin
            state_d  = ST_IDLE;
          end
        end
        default: begin
          // IDLE (and the unused encoding) holds; enable has no effect.
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Outputs are pure decodes of the registered state, so they are glitch-free
  // and aligned with count.
  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);

  // Invariants: DONE always coincides with a zero count, and RUN never holds
  // zero (otherwise the decrement would wrap to all-ones).
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!done || count == '0)
        else $error("counter_ff_sub_dec: done with non-zero count");
      assert (!busy || count != '0)
        else $error("counter_ff_sub_dec: running with zero count");
    end
  end

endmodule : counter_ff_sub_dec

// File: tb/tb_counter_ff_sub_dec.sv
// -----------------------------------------------------------------------------
// tb_counter_ff_sub_dec
//   Directed bench for counter_ff_sub_dec. Two instances share one clock:
//   dut0 (AUTO_RELOAD=0) and dut1 (AUTO_RELOAD=1), both WIDTH=4. Inputs are
//   changed 1 time unit after a rising edge; outputs are checked 1 time unit
//   after the edge that should have produced them.
// -----------------------------------------------------------------------------
module tb_counter_ff_sub_dec;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst0, en0, ld0;
  logic [W-1:0] lv0;
  logic [W-1:0] cnt0;
  logic         busy0, done0;
  logic         rst1, en1, ld1;
  logic [W-1:0] lv1;
  logic [W-1:0] cnt1;
  logic         busy1, done1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  counter_ff_sub_dec #(.WIDTH(W), .AUTO_RELOAD(1'b0)) dut0 (
    .clk        (clk),
    .reset      (rst0),
    .enable     (en0),
    .load       (ld0),
    .load_value (lv0),
    .count      (cnt0),
    .busy       (busy0),
    .done       (done0)
  );

  counter_ff_sub_dec #(.WIDTH(W), .AUTO_RELOAD(1'b1)) dut1 (
    .clk        (clk),
    .reset      (rst1),
    .enable     (en1),
    .load       (ld1),
    .load_value (lv1),
    .count      (cnt1),
    .busy       (busy1),
    .done       (done1)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // Advance one clock and move just past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect0(input string tag, input int c, input bit b, input bit d);
    check({tag, ".count"}, 32'(cnt0), 32'(c));
    check({tag, ".busy"},  32'(busy0), 32'(b));
    check({tag, ".done"},  32'(done0), 32'(d));
  endtask

  task automatic expect1(input string tag, input int c, input bit b, input bit d);
    check({tag, ".count"}, 32'(cnt1), 32'(c));
    check({tag, ".busy"},  32'(busy1), 32'(b));
    check({tag, ".done"},  32'(done1), 32'(d));
  endtask

  initial begin
    // 1. Reset with a concurrent load: load must be ignored.
    rst0 = 1'b1; en0 = 1'b1; ld0 = 1'b1; lv0 = 4'd7;
    rst1 = 1'b1; en1 = 1'b1; ld1 = 1'b1; lv1 = 4'd7;
    #1;
    for (int i = 0; i < 2; i++) begin
      tick();
      expect0($sformatf("rst0_%0d", i), 0, 1'b0, 1'b0);
      expect1($sformatf("rst1_%0d", i), 0, 1'b0, 1'b0);
    end
    rst0 = 1'b0; ld0 = 1'b0; en0 = 1'b0;
    rst1 = 1'b0; ld1 = 1'b0; en1 = 1'b0;
    tick();
    expect0("post_rst", 0, 1'b0, 1'b0);

    // 2. Load 5 and count down: 5,4,3,2,1 busy; 0 with done; then idle at 0.
    ld0 = 1'b1; lv0 = 4'd5; en0 = 1'b1;
    tick();
    ld0 = 1'b0;
    expect0("t2_load", 5, 1'b1, 1'b0);
    for (int c = 4; c >= 1; c--) begin
      tick();
      expect0($sformatf("t2_run%0d", c), c, 1'b1, 1'b0);
    end
    tick();
    expect0("t2_done", 0, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      tick();
      expect0($sformatf("t2_idle%0d", i), 0, 1'b0, 1'b0);
    end

    // 3. Load 3 with enable low: holds; then enable counts down with one done.
    ld0 = 1'b1; lv0 = 4'd3; en0 = 1'b0;
    tick();
    ld0 = 1'b0;
    expect0("t3_load", 3, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      expect0($sformatf("t3_hold%0d", i), 3, 1'b1, 1'b0);
    end
    en0 = 1'b1;
    tick(); expect0("t3_run2", 2, 1'b1, 1'b0);
    tick(); expect0("t3_run1", 1, 1'b1, 1'b0);
    tick(); expect0("t3_done", 0, 1'b0, 1'b1);
    tick(); expect0("t3_idle", 0, 1'b0, 1'b0);

    // 4. Load 9, reload with 12 when count reaches 2: no done, continues down.
    ld0 = 1'b1; lv0 = 4'd9;
    tick();
    ld0 = 1'b0;
    expect0("t4_load", 9, 1'b1, 1'b0);
    for (int c = 8; c >= 2; c--) begin
      tick();
      expect0($sformatf("t4_run%0d", c), c, 1'b1, 1'b0);
    end
    ld0 = 1'b1; lv0 = 4'd12;
    tick();
    ld0 = 1'b0;
    expect0("t4_reload", 12, 1'b1, 1'b0);
    tick(); expect0("t4_run11", 11, 1'b1, 1'b0);
    tick(); expect0("t4_run10", 10, 1'b1, 1'b0);

    // 5. Load 6, reset at count 3: cleared with no done; then load 0 stays idle.
    ld0 = 1'b1; lv0 = 4'd6;
    tick();
    ld0 = 1'b0;
    expect0("t5_load", 6, 1'b1, 1'b0);
    tick(); tick(); tick();
    expect0("t5_at3", 3, 1'b1, 1'b0);
    rst0 = 1'b1;
    tick();
    rst0 = 1'b0;
    expect0("t5_rst", 0, 1'b0, 1'b0);
    tick(); expect0("t5_after_rst", 0, 1'b0, 1'b0);
    ld0 = 1'b1; lv0 = 4'd0;
    tick();
    ld0 = 1'b0;
    expect0("t5_load0", 0, 1'b0, 1'b0);
    tick(); expect0("t5_load0_idle", 0, 1'b0, 1'b0);
    en0 = 1'b0;

    // 6. Auto-reload: load 2 -> 2,1,0,2,1,0,2,1,0; then load 4 in a DONE cycle.
    ld1 = 1'b1; lv1 = 4'd2; en1 = 1'b1;
    tick();
    ld1 = 1'b0;
    for (int p = 0; p < 3; p++) begin
      if (p != 0) tick();
      expect1($sformatf("t6_p%0d_c2", p), 2, 1'b1, 1'b0);
      tick(); expect1($sformatf("t6_p%0d_c1", p), 1, 1'b1, 1'b0);
      tick(); expect1($sformatf("t6_p%0d_c0", p), 0, 1'b0, 1'b1);
    end
    ld1 = 1'b1; lv1 = 4'd4;
    tick();
    ld1 = 1'b0;
    expect1("t6_load_in_done", 4, 1'b1, 1'b0);
    for (int c = 3; c >= 1; c--) begin
      tick();
      expect1($sformatf("t6_run%0d", c), c, 1'b1, 1'b0);
    end
    tick(); expect1("t6_done4", 0, 1'b0, 1'b1);
    tick(); expect1("t6_reload4", 4, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_counter_ff_sub_dec
